// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data RAM access, load extraction, WB handoff
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         MEM_valid,
    input  logic [153:0] EXE_MEM_bus_r,
    input  logic         WB_allow_in,
    input  logic [31:0]  dm_rdata,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    output logic         MEM_over,
    output logic [117:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic [31:0]  MEM_pc
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, HOLD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_load_data;
    logic        r_rst_d;

    logic        w_inst_load, w_inst_store, w_ls_word, w_lb_sign;
    logic [31:0] w_store_data, w_exe_result, w_lo_result, w_pc;
    logic [5:0]  w_hilo_cp0_flags;
    logic [7:0]  w_cp0r_addr;
    logic        w_syscall, w_eret, w_rf_wen;
    logic [4:0]  w_rf_wdest;

    assign {w_inst_load, w_inst_store, w_ls_word, w_lb_sign} = EXE_MEM_bus_r[153:150];
    assign w_store_data     = EXE_MEM_bus_r[149:118];
    assign w_exe_result     = EXE_MEM_bus_r[117:86];
    assign w_lo_result      = EXE_MEM_bus_r[85:54];
    assign w_hilo_cp0_flags = EXE_MEM_bus_r[53:48];
    assign w_cp0r_addr      = EXE_MEM_bus_r[47:40];
    assign w_syscall        = EXE_MEM_bus_r[39];
    assign w_eret           = EXE_MEM_bus_r[38];
    assign w_rf_wen         = EXE_MEM_bus_r[37];
    assign w_rf_wdest       = EXE_MEM_bus_r[36:32];
    assign w_pc             = EXE_MEM_bus_r[31:0];

    // Cycle after reset is forced to a bubble so an aborted access never writes.
    logic w_active;
    assign w_active = MEM_valid & ~rst & ~r_rst_d;

    logic [7:0]  w_rbyte;
    logic [31:0] w_load_ext;
    logic [3:0]  w_store_wen;
    logic [31:0] w_load_data;
    logic [31:0] w_mem_result;

    always_comb begin
        case (w_exe_result[1:0])
            2'd0:    w_rbyte = dm_rdata[7:0];
            2'd1:    w_rbyte = dm_rdata[15:8];
            2'd2:    w_rbyte = dm_rdata[23:16];
            default: w_rbyte = dm_rdata[31:24];
        endcase
    end

    assign w_load_ext  = w_ls_word ? dm_rdata
                                   : {{24{w_lb_sign & w_rbyte[7]}}, w_rbyte};
    assign w_store_wen = w_ls_word ? 4'b1111 : (4'b0001 << w_exe_result[1:0]);

    assign dm_addr  = w_exe_result;
    assign dm_wdata = w_ls_word ? w_store_data : {4{w_store_data[7:0]}};

    // Read data is live during LOAD_WAIT; afterwards the captured copy is used.
    assign w_load_data  = (r_state == LOAD_WAIT) ? w_load_ext : r_load_data;
    assign w_mem_result = w_inst_load ? w_load_data : w_exe_result;

    assign MEM_WB_bus = {w_rf_wen, w_rf_wdest, w_mem_result, w_lo_result,
                         w_hilo_cp0_flags, w_cp0r_addr, w_syscall, w_eret, w_pc};
    assign MEM_wdest  = w_rf_wdest & {5{MEM_valid}};
    assign MEM_pc     = w_pc;

    always_ff @(posedge clk) begin
        r_rst_d <= rst;
        if (rst) begin
            r_state     <= IDLE;
            r_load_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD_WAIT && w_active)
                r_load_data <= w_load_ext;
        end
    end

    always_comb begin
        w_next   = r_state;
        dm_wen   = 4'b0000;
        MEM_over = 1'b0;
        if (!w_active) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_inst_load) begin
                        w_next = LOAD_WAIT;
                    end else if (w_inst_store) begin
                        dm_wen   = w_store_wen;
                        MEM_over = 1'b1;
                        w_next   = WB_allow_in ? IDLE : HOLD;
                    end else begin
                        MEM_over = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    MEM_over = 1'b1;
                    w_next   = WB_allow_in ? IDLE : HOLD;
                end
                HOLD: begin
                    MEM_over = 1'b1;
                    if (WB_allow_in)
                        w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end
endmodule
